// File: rtl/rob_queue.sv
// Reorder buffer: circular queue of in-flight instructions. Entries are
// allocated in order at the tail, completed out of order by execution
// results, and retired in order from the head once done.
module rob_queue #(
  parameter int ROB_ADDR_WIDTH = 4,
  parameter int EXC_W          = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      rob_write_en,
  output logic                      rob_can_write,
  output logic [ROB_ADDR_WIDTH-1:0] rob_write_addr,
  input  logic                      write_reg_write_en,
  input  logic [4:0]                write_reg_write_addr,
  input  logic [EXC_W-1:0]          write_exception_type,
  input  logic                      write_is_delayslot,
  input  logic [31:0]               write_pc,
  input  logic                      update_en,
  input  logic [ROB_ADDR_WIDTH-1:0] update_addr,
  input  logic [31:0]               update_data,
  input  logic [EXC_W-1:0]          update_exception_type,
  input  logic                      rob_commit_en,
  output logic                      rob_can_commit,
  output logic                      commit_reg_write_en,
  output logic [4:0]                commit_reg_write_addr,
  output logic [31:0]               commit_reg_write_data,
  output logic [EXC_W-1:0]          commit_exception_type,
  output logic                      commit_is_delayslot,
  output logic [31:0]               commit_pc
);

  localparam int AW    = ROB_ADDR_WIDTH;
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // An all-zero exception code means no exception.
  function automatic logic exc_raised(input logic [EXC_W-1:0] e);
    return |e;
  endfunction

  // Pointers carry an extra wrap bit so full and empty can be told apart.
  logic [AW:0]       head, tail;
  logic [DEPTH-1:0]  valid, done;

  logic              reg_we_mem   [DEPTH];
  logic [4:0]        reg_addr_mem [DEPTH];
  logic [EXC_W-1:0]  exc_mem      [DEPTH];
  logic              ds_mem       [DEPTH];
  logic [31:0]       pc_mem       [DEPTH];
  logic [31:0]       result_mem   [DEPTH];

  logic [AW-1:0] head_idx, tail_idx;
  logic          empty, full;
  logic          do_write, do_commit, do_update;

  assign head_idx = head[AW-1:0];
  assign tail_idx = tail[AW-1:0];
  assign empty    = (head == tail);
  assign full     = (head_idx == tail_idx) && (head[AW] != tail[AW]);

  assign rob_can_write  = !full;
  assign rob_write_addr = tail_idx;
  assign rob_can_commit = !empty && done[head_idx];

  // Flush overrides every other operation in the same cycle.
  assign do_write  = rob_write_en && !full && !flush;
  assign do_commit = rob_commit_en && rob_can_commit && !flush;
  assign do_update = update_en && valid[update_addr] && !flush;

  // Control state: pointers and per-entry valid/done flags. The commit clear
  // is ordered after the update so a result arriving for the retiring head
  // is dropped with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      valid <= '0;
      done  <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      valid <= '0;
      done  <= '0;
    end else begin
      if (do_update) begin
        done[update_addr] <= 1'b1;
      end
      if (do_commit) begin
        valid[head_idx] <= 1'b0;
        done[head_idx]  <= 1'b0;
        head            <= head + PTR_ONE;
      end
      if (do_write) begin
        valid[tail_idx] <= 1'b1;
        done[tail_idx]  <= exc_raised(write_exception_type);
        tail            <= tail + PTR_ONE;
      end
    end
  end

  // Payload storage; contents are only meaningful while the entry is valid.
  always_ff @(posedge clk) begin
    if (do_write) begin
      reg_we_mem[tail_idx]   <= write_reg_write_en;
      reg_addr_mem[tail_idx] <= write_reg_write_addr;
      exc_mem[tail_idx]      <= write_exception_type;
      ds_mem[tail_idx]       <= write_is_delayslot;
      pc_mem[tail_idx]       <= write_pc;
      result_mem[tail_idx]   <= 32'h0;
    end
    if (do_update) begin
      result_mem[update_addr] <= update_data;
      if (exc_raised(update_exception_type)) begin
        exc_mem[update_addr] <= update_exception_type;
      end
    end
  end

  // Head entry is presented directly; an empty queue shows all zeros.
  always_comb begin
    commit_reg_write_en   = 1'b0;
    commit_reg_write_addr = '0;
    commit_reg_write_data = '0;
    commit_exception_type = '0;
    commit_is_delayslot   = 1'b0;
    commit_pc             = '0;
    if (!empty) begin
      commit_reg_write_en   = reg_we_mem[head_idx];
      commit_reg_write_addr = reg_addr_mem[head_idx];
      commit_reg_write_data = result_mem[head_idx];
      commit_exception_type = exc_mem[head_idx];
      commit_is_delayslot   = ds_mem[head_idx];
      commit_pc             = pc_mem[head_idx];
    end
  end

endmodule

// File: tb/tb_rob_queue.sv
// Testbench for rob_queue: a table of directed vectors plus hand-written
// corner-case sequences, with a reference model and an in-order scoreboard
// that checks every retired entry.
module tb_rob_queue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        rob_write_en;
  logic        rob_can_write;
  logic [3:0]  rob_write_addr;
  logic        write_reg_write_en;
  logic [4:0]  write_reg_write_addr;
  logic [3:0]  write_exception_type;
  logic        write_is_delayslot;
  logic [31:0] write_pc;
  logic        update_en;
  logic [3:0]  update_addr;
  logic [31:0] update_data;
  logic [3:0]  update_exception_type;
  logic        rob_commit_en;
  logic        rob_can_commit;
  logic        commit_reg_write_en;
  logic [4:0]  commit_reg_write_addr;
  logic [31:0] commit_reg_write_data;
  logic [3:0]  commit_exception_type;
  logic        commit_is_delayslot;
  logic [31:0] commit_pc;

  rob_queue #(.ROB_ADDR_WIDTH(4), .EXC_W(4)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .flush                 (flush),
    .rob_write_en          (rob_write_en),
    .rob_can_write         (rob_can_write),
    .rob_write_addr        (rob_write_addr),
    .write_reg_write_en    (write_reg_write_en),
    .write_reg_write_addr  (write_reg_write_addr),
    .write_exception_type  (write_exception_type),
    .write_is_delayslot    (write_is_delayslot),
    .write_pc              (write_pc),
    .update_en             (update_en),
    .update_addr           (update_addr),
    .update_data           (update_data),
    .update_exception_type (update_exception_type),
    .rob_commit_en         (rob_commit_en),
    .rob_can_commit        (rob_can_commit),
    .commit_reg_write_en   (commit_reg_write_en),
    .commit_reg_write_addr (commit_reg_write_addr),
    .commit_reg_write_data (commit_reg_write_data),
    .commit_exception_type (commit_exception_type),
    .commit_is_delayslot   (commit_is_delayslot),
    .commit_pc             (commit_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] pc;
    logic [3:0]  wexc;
    logic        ue;
    logic [3:0]  ua;
    logic [31:0] ud;
    logic [3:0]  uexc;
    logic        ce;
    logic        fl;
  } op_t;

  typedef struct packed {
    op_t        op;
    logic       e_cw;
    logic [3:0] e_addr;
    logic       e_cc;
  } vec_t;

  typedef struct {
    int          idx;
    logic        rwe;
    logic [4:0]  ra;
    logic        ds;
    logic [31:0] pc;
  } sb_t;

  int total = 0;
  int bad   = 0;

  op_t  op;
  vec_t tbl [11];
  sb_t  sb [$];

  int          mhead, mtail, mcnt;
  logic        mvalid [16];
  logic        mdone  [16];
  logic [31:0] mdata  [16];
  logic [3:0]  mexc   [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic mclear();
    for (int i = 0; i < 16; i++) begin
      mvalid[i] = 1'b0;
      mdone[i]  = 1'b0;
    end
    mhead = 0;
    mtail = 0;
    mcnt  = 0;
    sb.delete();
  endtask

  function automatic vec_t mkv(input int we, input int ue, input int ua, input int ce,
                               input int cw, input int addr, input int cc);
    vec_t v;
    v        = '0;
    v.op.we  = we[0];
    v.op.ue  = ue[0];
    v.op.ua  = ua[3:0];
    v.op.ud  = 32'hD000_0000 + 32'(ua);
    v.op.ce  = ce[0];
    v.e_cw   = cw[0];
    v.e_addr = addr[3:0];
    v.e_cc   = cc[0];
    return v;
  endfunction

  // One clock cycle: check state against the model, drive op, advance the
  // model, then step to just after the next rising edge.
  task automatic cyc();
    int   hi, ti;
    logic m_cw, m_cc;
    sb_t  e;
    hi   = mhead % 16;
    ti   = mtail % 16;
    m_cw = (mcnt < 16);
    m_cc = (mcnt > 0) && mdone[hi];
    chk("can_write", 32'(rob_can_write), 32'(m_cw));
    chk("write_addr", 32'(rob_write_addr), ti);
    chk("can_commit", 32'(rob_can_commit), 32'(m_cc));
    if (mcnt == 0) begin
      chk("empty_pc", commit_pc, 32'd0);
      chk("empty_exc", 32'(commit_exception_type), 32'd0);
    end
    flush                 = op.fl;
    rob_write_en          = op.we;
    write_pc              = op.pc;
    write_exception_type  = op.wexc;
    write_reg_write_en    = 1'($urandom_range(0, 1));
    write_reg_write_addr  = 5'($urandom_range(0, 31));
    write_is_delayslot    = 1'($urandom_range(0, 1));
    update_en             = op.ue;
    update_addr           = op.ua;
    update_data           = op.ud;
    update_exception_type = op.uexc;
    rob_commit_en         = op.ce;
    if (op.fl) begin
      mclear();
    end else begin
      if (op.ce && m_cc) begin
        e = sb.pop_front();
        chk("commit_idx", 32'(e.idx), hi);
        chk("commit_pc", commit_pc, e.pc);
        chk("commit_data", commit_reg_write_data, mdata[e.idx]);
        chk("commit_exc", 32'(commit_exception_type), 32'(mexc[e.idx]));
        chk("commit_rwe", 32'(commit_reg_write_en), 32'(e.rwe));
        chk("commit_ra", 32'(commit_reg_write_addr), 32'(e.ra));
        chk("commit_ds", 32'(commit_is_delayslot), 32'(e.ds));
      end
      if (op.ue && mvalid[op.ua]) begin
        mdata[op.ua] = op.ud;
        mdone[op.ua] = 1'b1;
        if (op.uexc != 4'h0) mexc[op.ua] = op.uexc;
      end
      if (op.ce && m_cc) begin
        mvalid[hi] = 1'b0;
        mdone[hi]  = 1'b0;
        mhead      = (mhead + 1) % 32;
        mcnt--;
      end
      if (op.we && m_cw) begin
        mvalid[ti] = 1'b1;
        mdone[ti]  = (op.wexc != 4'h0);
        mdata[ti]  = 32'h0;
        mexc[ti]   = op.wexc;
        e.idx = ti;
        e.rwe = write_reg_write_en;
        e.ra  = write_reg_write_addr;
        e.ds  = write_is_delayslot;
        e.pc  = op.pc;
        sb.push_back(e);
        mtail = (mtail + 1) % 32;
        mcnt++;
      end
    end
    op = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic write_n(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      op.we = 1'b1;
      op.pc = base + 32'(i * 4);
      cyc();
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 64 && mcnt > 0; k++) begin
      op.ue = 1'b1;
      op.ua = 4'(mhead % 16);
      op.ud = 32'h5500_0000 + 32'(k);
      cyc();
      op.ce = 1'b1;
      cyc();
    end
    chk("drained", 32'(mcnt), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    chk("rst_can_write", 32'(rob_can_write), 32'd1);
    chk("rst_write_addr", 32'(rob_write_addr), 32'd0);
    chk("rst_can_commit", 32'(rob_can_commit), 32'd0);
    chk("rst_commit_pc", commit_pc, 32'd0);
    chk("rst_commit_data", commit_reg_write_data, 32'd0);
    mclear();
    #2;
    rst = 1'b1;
  endtask

  initial begin
    op  = '0;
    rst = 1'b0;
    flush = 1'b0; rob_write_en = 1'b0; write_reg_write_en = 1'b0;
    write_reg_write_addr = 5'h0; write_exception_type = 4'h0;
    write_is_delayslot = 1'b0; write_pc = 32'h0; update_en = 1'b0;
    update_addr = 4'h0; update_data = 32'h0; update_exception_type = 4'h0;
    rob_commit_en = 1'b0;
    mclear();

    // Out-of-order completion, in-order retirement.
    tbl[0]  = mkv(1, 0, 0, 0, 1, 0, 0);
    tbl[1]  = mkv(1, 0, 0, 0, 1, 1, 0);
    tbl[2]  = mkv(1, 0, 0, 0, 1, 2, 0);
    tbl[3]  = mkv(0, 1, 2, 0, 1, 3, 0);
    tbl[4]  = mkv(0, 1, 1, 0, 1, 3, 0);
    tbl[5]  = mkv(0, 0, 0, 1, 1, 3, 0);
    tbl[6]  = mkv(0, 1, 0, 0, 1, 3, 0);
    tbl[7]  = mkv(0, 0, 0, 1, 1, 3, 1);
    tbl[8]  = mkv(0, 0, 0, 1, 1, 3, 1);
    tbl[9]  = mkv(0, 0, 0, 1, 1, 3, 1);
    tbl[10] = mkv(0, 0, 0, 0, 1, 3, 0);

    #12;
    chk("reset_can_write", 32'(rob_can_write), 32'd1);
    chk("reset_write_addr", 32'(rob_write_addr), 32'd0);
    chk("reset_can_commit", 32'(rob_can_commit), 32'd0);
    chk("reset_commit_pc", commit_pc, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) begin
      chk("tbl_can_write", 32'(rob_can_write), 32'(tbl[i].e_cw));
      chk("tbl_write_addr", 32'(rob_write_addr), 32'(tbl[i].e_addr));
      chk("tbl_can_commit", 32'(rob_can_commit), 32'(tbl[i].e_cc));
      op    = tbl[i].op;
      op.pc = 32'h0000_1000 + 32'(i * 4);
      cyc();
    end

    // Exception raised at allocation is committable next cycle.
    op.we = 1'b1; op.pc = 32'h8000_0010; op.wexc = 4'h3;
    cyc();
    chk("wexc_can_commit", 32'(rob_can_commit), 32'd1);
    chk("wexc_exc", 32'(commit_exception_type), 32'h3);
    chk("wexc_pc", commit_pc, 32'h8000_0010);
    op.ce = 1'b1;
    cyc();

    // A null update exception never clears an existing one; non-null overrides.
    op.we = 1'b1; op.pc = 32'h0000_4000; op.wexc = 4'h5;
    cyc();
    op.ue = 1'b1; op.ua = 4'((mtail + 15) % 16); op.ud = 32'h1234_5678;
    cyc();
    op.we = 1'b1; op.pc = 32'h0000_4004;
    cyc();
    op.ue = 1'b1; op.ua = 4'((mtail + 15) % 16); op.ud = 32'h9ABC_DEF0; op.uexc = 4'h7;
    cyc();
    op.we = 1'b1; op.pc = 32'h0000_4008;
    cyc();
    op.ue = 1'b1; op.ua = 4'(mtail % 16); op.ud = 32'hDEAD_0001;  // invalid slot
    cyc();
    op.ce = 1'b1;
    cyc();
    op.ce = 1'b1;
    cyc();
    chk("inv_update_cc", 32'(rob_can_commit), 32'd0);
    drain();

    // Fill to full; the 17th write is refused.
    write_n(16, 32'h0000_6000);
    chk("full_can_write", 32'(rob_can_write), 32'd0);
    op.we = 1'b1; op.pc = 32'hFFFF_FFF0;
    cyc();
    chk("full_still", 32'(rob_can_write), 32'd0);
    op.ue = 1'b1; op.ua = 4'(mhead % 16); op.ud = 32'h0000_00A1;
    cyc();
    op.we = 1'b1; op.pc = 32'hFFFF_FFF4; op.ce = 1'b1;
    cyc();
    chk("full_commit_cw", 32'(rob_can_write), 32'd1);
    chk("full_commit_cnt", 32'(mcnt), 32'd15);

    // Update hitting the head in its retire cycle has no lasting effect.
    op.ue = 1'b1; op.ua = 4'(mhead % 16); op.ud = 32'h0000_00B2;
    cyc();
    op.ce = 1'b1; op.ue = 1'b1; op.ua = 4'(mhead % 16); op.ud = 32'h0000_0BAD;
    cyc();
    chk("head_upd_cc", 32'(rob_can_commit), 32'd0);
    drain();

    // Streaming: one write, update and commit per cycle across pointer wraps.
    for (int i = 0; i < 40; i++) begin
      op.we = 1'b1;
      op.pc = 32'h0000_2000 + 32'(i * 4);
      op.ue = (mcnt > 0);
      op.ua = 4'((mtail + 15) % 16);
      op.ud = 32'h0000_3000 + 32'(i);
      op.ce = 1'b1;
      cyc();
    end
    drain();

    // Flush with five live entries.
    write_n(5, 32'h0000_7000);
    op.fl = 1'b1; op.we = 1'b1; op.ue = 1'b1; op.ua = 4'(mhead % 16); op.ce = 1'b1;
    cyc();
    op.ue = 1'b1; op.ua = 4'h1; op.ud = 32'h0000_0F1F;
    cyc();
    chk("flush_cc", 32'(rob_can_commit), 32'd0);
    chk("flush_addr", 32'(rob_write_addr), 32'd0);

    // Reset mid-burst.
    write_n(5, 32'h0000_8000);
    do_reset();
    op.ue = 1'b1; op.ua = 4'h1; op.ud = 32'h0000_0E5E;
    cyc();
    chk("rst_upd_cc", 32'(rob_can_commit), 32'd0);
    chk("rst_upd_addr", 32'(rob_write_addr), 32'd0);
    write_n(3, 32'h0000_9000);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
